// File: rtl/rst_ctrl.sv
// rst_ctrl: merges watchdog/software/external reset requests into a stretched system reset with hold-off, cause flags and count
module rst_ctrl #(
   parameter int WIDTH  = 8,
   parameter int PW_RST = 16,
   parameter int HO_RST = 8
) (
   input  logic             pclk_i,
   input  logic             prst_i,
   input  logic             psel_i,
   input  logic             penable_i,
   input  logic             pwrite_i,
   input  logic [WIDTH-1:0] paddr_i,
   input  logic [WIDTH-1:0] pwdata_i,
   input  logic             wdt_rst_i,
   input  logic             ext_rst_i,
   output logic             pready_o,
   output logic [WIDTH-1:0] prdata_o,
   output logic             sys_rst_o,
   output logic             rst_done_o
);
   typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;
   localparam logic [WIDTH-1:0] A_PW    = WIDTH'(8'hB0);
   localparam logic [WIDTH-1:0] A_HO    = WIDTH'(8'hB4);
   localparam logic [WIDTH-1:0] A_CAUSE = WIDTH'(8'hB8);
   localparam logic [WIDTH-1:0] A_CTL   = WIDTH'(8'hBC);
   localparam logic [WIDTH-1:0] A_CNT   = WIDTH'(8'hC0);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d, pw_q, pw_d, ho_q, ho_d, count_q, count_d, prdata_q, prdata_d;
   logic [2:0]       cause_q, cause_d;
   logic             sw_q, sw_d, pready_q, pready_d, sys_rst_q, sys_rst_d, done_q, done_d;
   logic             access, wr, req;
   logic [WIDTH-1:0] rdata;
   always_comb begin
      access    = psel_i & penable_i & ~pready_q;
      wr        = access & pwrite_i;
      req       = wdt_rst_i | ext_rst_i | sw_q;
      pready_d  = access;
      state_d   = state_q;
      cnt_d     = cnt_q;
      sys_rst_d = sys_rst_q;
      done_d    = 1'b0;
      count_d   = count_q;
      pw_d      = (wr && paddr_i == A_PW) ? pwdata_i : pw_q;
      ho_d      = (wr && paddr_i == A_HO) ? ho_q ^ ho_q ^ pwdata_i : ho_q;
      sw_d      = wr && paddr_i == A_CTL && pwdata_i[0];
      // set beats a same-cycle W1C clear
      cause_d   = (cause_q & ~((wr && paddr_i == A_CAUSE) ? pwdata_i[2:0] : 3'b000))
                | {ext_rst_i, sw_q, wdt_rst_i};
      rdata     = (paddr_i == A_PW)    ? pw_q :
                  (paddr_i == A_HO)    ? ho_q :
                  (paddr_i == A_CAUSE) ? WIDTH'(cause_q) :
                  (paddr_i == A_CNT)   ? count_q : '0;
      prdata_d  = (access && !pwrite_i) ? rdata : prdata_q;
      unique case (state_q)
         IDLE: if (req) begin
            state_d   = ASSERT;
            sys_rst_d = 1'b1;
            cnt_d     = (pw_q == '0) ? '0 : pw_q - WIDTH'(1);
            count_d   = (count_q == '1) ? count_q : count_q + WIDTH'(1);
         end
         ASSERT: if (cnt_q == '0) begin
            state_d   = HOLD;
            sys_rst_d = 1'b0;
            cnt_d     = (ho_q == '0) ? '0 : ho_q - WIDTH'(1);
         end else cnt_d = cnt_q - WIDTH'(1);
         HOLD: if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else cnt_d = cnt_q - WIDTH'(1);
         default: state_d = IDLE;
      endcase
      if (wr && paddr_i == A_CNT) count_d = '0;
   end
   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pw_q      <= WIDTH'(PW_RST);
         ho_q      <= WIDTH'(HO_RST);
         cause_q   <= '0;
         count_q   <= '0;
         sw_q      <= 1'b0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         sys_rst_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pw_q      <= pw_d;
         ho_q      <= ho_d;
         cause_q   <= cause_d;
         count_q   <= count_d;
         sw_q      <= sw_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         sys_rst_q <= sys_rst_d;
         done_q    <= done_d;
      end
   end
   assign pready_o   = pready_q;
   assign prdata_o   = prdata_q;
   assign sys_rst_o  = sys_rst_q;
   assign rst_done_o = done_q;
endmodule

// File: tb/tb_rst_ctrl.sv
// tb_rst_ctrl: table-driven register checks plus directed reset-sequence scenarios for rst_ctrl
module tb_rst_ctrl;
   logic       clk = 1'b0, prst = 1'b1, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0] paddr = '0, pwdata = '0;
   logic       wdt = 1'b0, ext = 1'b0;
   logic       pready, sys_rst, done;
   logic [7:0] prdata;
   int         pass = 0, total = 0;
   rst_ctrl #(.WIDTH(8), .PW_RST(16), .HO_RST(8)) dut (
      .pclk_i(clk), .prst_i(prst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .wdt_rst_i(wdt), .ext_rst_i(ext),
      .pready_o(pready), .prdata_o(prdata), .sys_rst_o(sys_rst), .rst_done_o(done)
   );
   always #5 clk = ~clk;
   typedef struct {logic wr; logic [7:0] addr; logic [7:0] data; logic [7:0] exp;} vec_t;
   vec_t vecs[16];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else pass++;
   endtask
   task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] data, output logic [7:0] rd);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(negedge clk);
      check("pready_setup", pready, 0);
      penable = 1'b1;
      @(negedge clk);
      check("pready_hi", pready, 1);
      rd = prdata;
      @(negedge clk);
      check("pready_lo", pready, 0);
      psel = 1'b0; penable = 1'b0;
   endtask
   task automatic run_seq(output int hi, output int lo);
      int t = 0;
      while (!sys_rst && t < 50) begin @(negedge clk); t++; end
      check("seq_start", sys_rst, 1);
      hi = 0; lo = 0;
      while (sys_rst && hi < 1000) begin hi++; @(negedge clk); end
      while (!done && lo < 1000) begin lo++; @(negedge clk); end
      check("done_hi", done, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
   endtask
   initial begin
      logic [7:0] rd;
      int hi, lo, n, idx;
      logic started;
      logic [0:5] pat_r, pat_d;
      vecs[0]  = '{0, 8'hB0, 8'h00, 8'd16};
      vecs[1]  = '{0, 8'hB4, 8'h00, 8'd8};
      vecs[2]  = '{0, 8'hB8, 8'h00, 8'd0};
      vecs[3]  = '{0, 8'hC0, 8'h00, 8'd0};
      vecs[4]  = '{0, 8'hBC, 8'h00, 8'd0};
      vecs[5]  = '{1, 8'hB0, 8'h05, 8'd0};
      vecs[6]  = '{0, 8'hB0, 8'h00, 8'd5};
      vecs[7]  = '{1, 8'hB4, 8'h02, 8'd0};
      vecs[8]  = '{0, 8'hB4, 8'h00, 8'd2};
      vecs[9]  = '{1, 8'hB8, 8'hFF, 8'd0};
      vecs[10] = '{0, 8'hB8, 8'h00, 8'd0};
      vecs[11] = '{1, 8'h10, 8'hAA, 8'd0};
      vecs[12] = '{0, 8'h10, 8'h00, 8'd0};
      vecs[13] = '{1, 8'hB0, 8'd16, 8'd0};
      vecs[14] = '{1, 8'hB4, 8'd8, 8'd0};
      vecs[15] = '{0, 8'hB0, 8'h00, 8'd16};
      repeat (2) @(negedge clk);
      check("rst_sys_rst", sys_rst, 0);
      check("rst_done", done, 0);
      check("rst_pready", pready, 0);
      check("rst_prdata", prdata, 0);
      prst = 1'b0;
      foreach (vecs[i]) begin
         apb(vecs[i].wr, vecs[i].addr, vecs[i].data, rd);
         if (!vecs[i].wr) check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
      end
      // watchdog pulse with default widths
      @(negedge clk); wdt = 1'b1; @(negedge clk); wdt = 1'b0;
      run_seq(hi, lo);
      check("wdt_hi", hi, 16);
      check("wdt_lo", lo, 8);
      apb(0, 8'hB8, 0, rd); check("wdt_cause", rd, 8'h01);
      apb(0, 8'hC0, 0, rd); check("wdt_count", rd, 1);
      apb(1, 8'hB8, 8'h01, rd);
      apb(0, 8'hB8, 0, rd); check("cause_clr1", rd, 0);
      // software reset
      apb(1, 8'hB0, 8'd3, rd);
      apb(1, 8'hB4, 8'd0, rd);
      apb(1, 8'hBC, 8'h01, rd);
      run_seq(hi, lo);
      check("sw_hi", hi, 3);
      check("sw_lo", lo, 1);
      apb(0, 8'hB8, 0, rd); check("sw_cause", rd, 8'h02);
      apb(1, 8'hB8, 8'h02, rd);
      apb(0, 8'hB8, 0, rd); check("cause_clr2", rd, 0);
      // simultaneous sources, then ext during ASSERT and HOLDOFF
      apb(1, 8'hB0, 8'd4, rd);
      apb(1, 8'hB4, 8'd3, rd);
      @(negedge clk); wdt = 1'b1; ext = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         wdt = 1'b0;
         ext = (i == 1 || i == 5);
         check($sformatf("ovl_rst%0d", i), sys_rst, i < 4);
         check($sformatf("ovl_done%0d", i), done, i == 7);
      end
      apb(0, 8'hB8, 0, rd); check("ovl_cause", rd, 8'h05);
      apb(0, 8'hC0, 0, rd); check("ovl_count", rd, 3);
      // zero widths behave as one cycle
      apb(1, 8'hB0, 8'd0, rd);
      apb(1, 8'hB4, 8'd0, rd);
      @(negedge clk); wdt = 1'b1; @(negedge clk); wdt = 1'b0;
      run_seq(hi, lo);
      check("zero_hi", hi, 1);
      check("zero_lo", lo, 1);
      // held external level with minimal widths, run into saturation
      apb(1, 8'hB0, 8'd1, rd);
      apb(1, 8'hB4, 8'd1, rd);
      @(negedge clk); ext = 1'b1;
      n = 0; idx = 0; started = 1'b0; pat_r = '0; pat_d = '0;
      for (int t = 0; t < 2000 && n < 300; t++) begin
         @(negedge clk);
         if (sys_rst) begin n++; started = 1'b1; end
         if (started && idx < 6) begin pat_r[idx] = sys_rst; pat_d[idx] = done; idx++; end
      end
      ext = 1'b0;
      check("held_seqs", n, 300);
      check("held_rst_pat", pat_r, 6'b100100);
      check("held_done_pat", pat_d, 6'b001001);
      repeat (10) @(negedge clk);
      apb(0, 8'hC0, 0, rd); check("sat_count", rd, 255);
      apb(1, 8'hC0, 8'h00, rd);
      apb(0, 8'hC0, 0, rd); check("count_clr", rd, 0);
      // reset in the 5th ASSERT cycle
      apb(1, 8'hB0, 8'd6, rd);
      apb(1, 8'hB4, 8'd5, rd);
      @(negedge clk); wdt = 1'b1; @(negedge clk); wdt = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_pre", sys_rst, 1);
      prst = 1'b1;
      @(negedge clk);
      check("mid_sys_rst", sys_rst, 0);
      @(negedge clk); prst = 1'b0;
      n = 0;
      repeat (30) begin @(negedge clk); n += (done | sys_rst); end
      check("mid_no_done", n, 0);
      apb(0, 8'hB0, 0, rd); check("mid_pw", rd, 16);
      apb(0, 8'hB4, 0, rd); check("mid_ho", rd, 8);
      apb(0, 8'hB8, 0, rd); check("mid_cause", rd, 0);
      apb(0, 8'hC0, 0, rd); check("mid_count", rd, 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
